ttl165_scan_ctrl: RTL

Scan controller that sits directly downstream of a TTL74x165 chain. It drives the chain's parallel-load, shift clock and clock-inhibit inputs, samples the serial output `QH`, and presents the captured word as a parallel result with a one-cycle valid strobe. It supports a single 165 or a cascaded chain, for example switch-bank and keypad readers in the same design.

---
 rtl/ttl_scan_pkg.sv | 24 ++
 rtl/ttl_phase_timer.sv | 36 +++
 rtl/ttl165_scan_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ttl_scan_pkg.sv
// Shared types and helpers for the TTL74x165 scan controller.
// Holds the FSM state encoding, the default phase length and the counter-width helper.
package ttl_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_DONE     = 3'd5
    } scan_state_e;

    localparam int DEFAULT_DIV   = 4;
    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ttl_phase_timer.sv
// DIV-cycle down-counter shared by every timed phase of the scan FSM.
// A load pulse starts a phase; o_done marks its last cycle.
module ttl_phase_timer
    import ttl_scan_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam int              PH_W   = cnt_width(DIV);
    localparam logic [PH_W-1:0] RELOAD = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0] ZERO   = {PH_W{1'b0}};
    localparam logic [PH_W-1:0] ONE    = PH_W'(1);

    logic [PH_W-1:0] r_cnt;

    // Reload on phase entry, then count down and rest at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= ZERO;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != ZERO) begin
            r_cnt <= r_cnt - ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_done = (r_cnt == ZERO);

endmodule

// File: rtl/ttl165_scan_ctrl.sv
// Scan controller for a TTL74x165 chain: load, shift WIDTH bits MSB first, present word.
// Optional TTL165_CHANGE_DETECT_EN suppresses VALID when the word did not change.
module ttl165_scan_ctrl
    import ttl_scan_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             START,
    input  logic             CONT,
    input  logic             SER_IN,
    output logic             PL_n,
    output logic             SCLK,
    output logic             CLK_INH,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    output logic             BUSY
);

    localparam int               BIT_W    = cnt_width(WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    scan_state_e       r_state;
    logic [BIT_W-1:0]  r_bit;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  r_data;
    logic              r_pl_n;
    logic              r_sclk;
    logic              r_clk_inh;
    logic              r_valid;
    logic              r_busy;

    logic              w_tmr_load;
    logic              w_tmr_done;
    logic              w_last_bit;
    logic              w_frame_end;
    logic              w_valid_en;
    logic [WIDTH-1:0]  w_shift_next;

    ttl_phase_timer #(
        .DIV (DIV)
    ) u_timer (
        .i_clk   (CLK),
        .i_rst_n (RST_n),
        .i_load  (w_tmr_load),
        .o_done  (w_tmr_done)
    );

    assign w_last_bit   = (r_bit == BIT_LAST);
    assign w_frame_end  = (r_state == ST_SHIFT_HI) & w_tmr_done & w_last_bit;
    assign w_shift_next = (r_shift << 1) | WIDTH'(SER_IN);

    // Restart the phase timer on every transition into a timed state.
    always_comb begin
        w_tmr_load = 1'b0;
        case (r_state)
            ST_IDLE:                        w_tmr_load = START | CONT;
            ST_LOAD, ST_SETTLE, ST_SHIFT_LO: w_tmr_load = w_tmr_done;
            ST_SHIFT_HI:                    w_tmr_load = w_tmr_done & ~w_last_bit;
            ST_DONE:                        w_tmr_load = CONT;
            default:                        w_tmr_load = 1'b0;
        endcase
    end

`ifdef TTL165_CHANGE_DETECT_EN
    logic r_first;

    // First completed frame after reset always reports, even if the word is zero.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_first <= 1'b1;
        end else if (w_frame_end) begin
            r_first <= 1'b0;
        end else begin
            r_first <= r_first;
        end
    end

    assign w_valid_en = r_first | (r_shift != r_data);
`else
    assign w_valid_en = 1'b1;
`endif

    // Scan FSM; outputs are set on the transition so each reflects the state it enters.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= ST_IDLE;
            r_bit     <= {BIT_W{1'b0}};
            r_shift   <= {WIDTH{1'b0}};
            r_data    <= {WIDTH{1'b0}};
            r_pl_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_clk_inh <= 1'b1;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START | CONT) begin
                        r_state <= ST_LOAD;
                        r_pl_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_tmr_done) begin
                        r_state   <= ST_SETTLE;
                        r_pl_n    <= 1'b1;
                        r_clk_inh <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_done) begin
                        r_state <= ST_SHIFT_LO;
                        r_bit   <= {BIT_W{1'b0}};
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_tmr_done) begin
                        r_shift <= w_shift_next;
                        r_state <= ST_SHIFT_HI;
                        r_sclk  <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (w_tmr_done) begin
                        r_sclk <= 1'b0;
                        if (w_last_bit) begin
                            r_state   <= ST_DONE;
                            r_clk_inh <= 1'b1;
                            r_data    <= r_shift;
                            r_valid   <= w_valid_en;
                        end else begin
                            r_bit   <= r_bit + BIT_ONE;
                            r_state <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_DONE: begin
                    if (CONT) begin
                        r_state <= ST_LOAD;
                        r_pl_n  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_pl_n    <= 1'b1;
                    r_sclk    <= 1'b0;
                    r_clk_inh <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign PL_n    = r_pl_n;
    assign SCLK    = r_sclk;
    assign CLK_INH = r_clk_inh;
    assign DATA    = r_data;
    assign VALID   = r_valid;
    assign BUSY    = r_busy;

endmodule
